// File: rtl/ram_loader_pkg.sv
// Shared widths, depth and state encoding for the RAM loader.
// RAM_LOADER_VERIFY_EN (when defined) enables the readback states used by ram_loader.
package ram_loader_pkg;
  localparam int ADDR_WIDTH  = 4;
  localparam int DATA_WIDTH  = 8;
  localparam int DEPTH       = 16;
  localparam int COUNT_WIDTH = ADDR_WIDTH + 1;

  typedef logic [ADDR_WIDTH-1:0]  addr_t;
  typedef logic [DATA_WIDTH-1:0]  data_t;
  typedef logic [COUNT_WIDTH-1:0] count_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_WRITE     = 3'd2,
    ST_RD_ADDR   = 3'd3,
    ST_RD_SAMPLE = 3'd4,
    ST_CHECK     = 3'd5,
    ST_DONE      = 3'd6,
    ST_ERROR     = 3'd7
  } state_t;
endpackage

// File: rtl/ram_loader_if.sv
// Byte stream, RAM programming pins and status of the RAM loader.
// master = the loader itself, slave = the source/RAM/controller side.
interface ram_loader_if;
  import ram_loader_pkg::*;

  logic   start;
  data_t  byte_data;
  logic   byte_valid;
  logic   last;
  logic   byte_ready;
  logic   ram_program_mode;
  data_t  ram_data_program;
  addr_t  ram_address;
  logic   ram_write_enable;
  logic   ram_read_enable;
  data_t  wbus;
  logic   busy;
  logic   done;
  logic   error;
  count_t count;

  modport master (
    input  start, byte_data, byte_valid, last, wbus,
    output byte_ready, ram_program_mode, ram_data_program, ram_address,
           ram_write_enable, ram_read_enable, busy, done, error, count
  );

  modport slave (
    output start, byte_data, byte_valid, last, wbus,
    input  byte_ready, ram_program_mode, ram_data_program, ram_address,
           ram_write_enable, ram_read_enable, busy, done, error, count
  );
endinterface

// File: rtl/ram_loader_xor_accum.sv
// XOR accumulator: clear has priority over enable; sum folds in data when enabled.
module xor_accum #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] sum
);
  always_ff @(posedge clk) begin
    if (!reset_n)
      sum <= '0;
    else if (clear)
      sum <= '0;
    else if (enable)
      sum <= sum ^ data;
  end
endmodule

// File: rtl/ram_loader.sv
// Streams bytes into the 16x8 RAM from address 0 upward, one byte per two cycles max.
// Define RAM_LOADER_VERIFY_EN to add an XOR-checksum readback pass after the load.
module ram_loader
  import ram_loader_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  ram_loader_if.master  bus
);
  state_t state_reg;
  addr_t  address_reg;
  data_t  data_reg;
  logic   last_reg;
  count_t count_reg;
  logic   byte_ready_reg;
  logic   program_mode_reg;
  logic   write_enable_reg;
  logic   busy_reg;
  logic   done_reg;
  logic   start_accept;

  assign start_accept = bus.start && !busy_reg;

`ifdef RAM_LOADER_VERIFY_EN
  logic  read_enable_reg;
  logic  error_reg;
  data_t checksum;
  data_t readback;

  xor_accum #(.WIDTH(DATA_WIDTH)) u_checksum (
    .clk(clk), .reset_n(reset_n), .clear(start_accept),
    .enable(state_reg == ST_WRITE), .data(data_reg), .sum(checksum)
  );

  xor_accum #(.WIDTH(DATA_WIDTH)) u_readback (
    .clk(clk), .reset_n(reset_n), .clear(start_accept),
    .enable(state_reg == ST_RD_SAMPLE), .data(bus.wbus), .sum(readback)
  );

  assign bus.ram_read_enable = read_enable_reg;
  assign bus.error           = error_reg;
`else
  assign bus.ram_read_enable = 1'b0;
  assign bus.error           = 1'b0;
`endif

  assign bus.byte_ready       = byte_ready_reg;
  assign bus.ram_program_mode = program_mode_reg;
  assign bus.ram_data_program = data_reg;
  assign bus.ram_address      = address_reg;
  assign bus.ram_write_enable = write_enable_reg;
  assign bus.busy             = busy_reg;
  assign bus.done             = done_reg;
  assign bus.count            = count_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg        <= ST_IDLE;
      address_reg      <= '0;
      data_reg         <= '0;
      last_reg         <= 1'b0;
      count_reg        <= '0;
      byte_ready_reg   <= 1'b0;
      program_mode_reg <= 1'b0;
      write_enable_reg <= 1'b0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
`ifdef RAM_LOADER_VERIFY_EN
      read_enable_reg  <= 1'b0;
      error_reg        <= 1'b0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (bus.start) begin
            state_reg        <= ST_LOAD;
            address_reg      <= '0;
            count_reg        <= '0;
            done_reg         <= 1'b0;
            byte_ready_reg   <= 1'b1;
            program_mode_reg <= 1'b1;
            busy_reg         <= 1'b1;
`ifdef RAM_LOADER_VERIFY_EN
            error_reg        <= 1'b0;
`endif
          end
        end
        ST_LOAD: begin
          if (bus.byte_valid) begin
            data_reg         <= bus.byte_data;
            last_reg         <= bus.last;
            byte_ready_reg   <= 1'b0;
            write_enable_reg <= 1'b1;
            state_reg        <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          write_enable_reg <= 1'b0;
          count_reg        <= count_reg + count_t'(1);
          // The top address ends the load so the address can never wrap.
          if (last_reg || address_reg == addr_t'(DEPTH - 1)) begin
            address_reg      <= '0;
            program_mode_reg <= 1'b0;
`ifdef RAM_LOADER_VERIFY_EN
            read_enable_reg  <= 1'b1;
            state_reg        <= ST_RD_ADDR;
`else
            done_reg         <= 1'b1;
            busy_reg         <= 1'b0;
            state_reg        <= ST_DONE;
`endif
          end else begin
            address_reg    <= address_reg + addr_t'(1);
            byte_ready_reg <= 1'b1;
            state_reg      <= ST_LOAD;
          end
        end
`ifdef RAM_LOADER_VERIFY_EN
        ST_RD_ADDR: state_reg <= ST_RD_SAMPLE;
        ST_RD_SAMPLE: begin
          if (address_reg == addr_t'(count_reg - count_t'(1))) begin
            read_enable_reg <= 1'b0;
            state_reg       <= ST_CHECK;
          end else begin
            address_reg <= address_reg + addr_t'(1);
            state_reg   <= ST_RD_ADDR;
          end
        end
        ST_CHECK: begin
          busy_reg <= 1'b0;
          if (readback == checksum) begin
            done_reg  <= 1'b1;
            state_reg <= ST_DONE;
          end else begin
            error_reg <= 1'b1;
            state_reg <= ST_ERROR;
          end
        end
`endif
        default: state_reg <= ST_IDLE;
      endcase
    end
  end
endmodule
